// File: rtl/instr_queue.sv
// Circular instruction FIFO (instr + pc) feeding the decoder; one push and one issue per cycle.
// Latency: push-to-issue 1 cycle, or 0 on an empty queue when INSTR_QUEUE_BYPASS_EN is defined.
// Backpressure: registered full refuses pushes (no same-cycle pop credit); update_stat holds the head.
module instr_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  update_stat,
    input  logic                  flush,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_instr,
    input  logic [31:0]           fetch_pc,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  decode_enable,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           instr_mem [DEPTH];
    logic [31:0]           pc_mem    [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count_next;

    logic empty;
    logic can_issue;
    logic push_ok;
    logic push;
    logic issue;
    logic bypass;

    always_comb begin
        empty     = (count == '0);
        can_issue = rdy && !flush && !update_stat;
        push_ok   = rdy && !flush && fetch_valid && !full;
        issue     = can_issue && !empty;
`ifdef INSTR_QUEUE_BYPASS_EN
        // Empty queue: hand the offered word straight to the decoder without storing it.
        bypass    = can_issue && push_ok && empty;
`else
        bypass    = 1'b0;
`endif
        push          = push_ok && !bypass;
        decode_enable = issue || bypass;
        instr         = bypass ? fetch_instr : instr_mem[head];
        instr_pc      = bypass ? fetch_pc    : pc_mem[head];
    end

    always_comb begin
        count_next = count;
        if (push && !issue) begin
            count_next = count + 1'b1;
        end else if (issue && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                full  <= 1'b0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (issue) begin
                    head <= head + 1'b1;
                end
                count <= count_next;
                full  <= (count_next == FULL_COUNT);
            end
        end
    end

    // Storage carries no reset; contents are only observed behind a valid count.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instr_mem[tail] <= fetch_instr;
            pc_mem[tail]    <= fetch_pc;
        end
    end

endmodule
